player_lasers: RTL and testbench

PLAYER_LASERS -- requirements
Module: player_lasers

---
 rtl/player_lasers.sv | 131 +++++++++++++
 tb/tb_player_lasers.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_lasers.sv
`default_nettype none
//============================================================================
// Module      : player_lasers
// Description : Four-slot player laser pool. Launches on a fire edge, moves
//               active lasers upward each frame and retires them on a hit
//               or when they leave the top of the screen.
// Revision    : 1.0 - initial release
//============================================================================
module player_lasers #(
    parameter int LASER_SPEED = 8,
    parameter int COOLDOWN    = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fire,
    input  logic [9:0] shipX,
    input  logic [9:0] shipY,
    input  logic [9:0] ship_width,
    input  logic [9:0] laser_width,
    input  logic [9:0] laser_height,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       hit3,
    input  logic       hit4,
    output logic [9:0] PX1,
    output logic [9:0] PX2,
    output logic [9:0] PX3,
    output logic [9:0] PX4,
    output logic [9:0] PY1,
    output logic [9:0] PY2,
    output logic [9:0] PY3,
    output logic [9:0] PY4,
    output logic       PL1,
    output logic       PL2,
    output logic       PL3,
    output logic       PL4,
    output logic [7:0] shots_fired
);

    localparam int                c_CD_W     = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [c_CD_W-1:0] c_COOLDOWN = c_CD_W'(COOLDOWN);
    localparam logic [9:0]        c_SPEED    = 10'(LASER_SPEED);

    logic [3:0]        r_pl;
    logic [9:0]        r_px [4];
    logic [9:0]        r_py [4];
    logic              r_fire_prev;
    logic [c_CD_W-1:0] r_cooldown;
    logic [7:0]        r_shots;

    logic [3:0] w_hit;
    logic [9:0] w_launch_x;
    logic [9:0] w_launch_y;
    logic       w_trigger;
    logic       w_any_free;
    logic       w_launch;
    logic [1:0] w_slot;

    assign w_hit      = {hit4, hit3, hit2, hit1};
    assign w_launch_x = shipX + {1'b0, ship_width[9:1]} - {1'b0, laser_width[9:1]};
    assign w_launch_y = (shipY < laser_height) ? 10'd0 : (shipY - laser_height);
    assign w_trigger  = fire & ~r_fire_prev;
    assign w_any_free = ~&r_pl;
    assign w_launch   = w_trigger && (r_cooldown == '0) && w_any_free;

    // Lowest-index free slot wins; scanning downward lets slot 0 overwrite.
    always_comb begin
        w_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_pl[i]) begin
                w_slot = 2'(i);
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_pl        <= '0;
            r_fire_prev <= 1'b1;
            r_cooldown  <= '0;
            r_shots     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_fire_prev <= fire;

            if (w_launch) begin
                r_cooldown <= c_COOLDOWN;
                r_shots    <= r_shots + 8'd1;
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - 1'b1;
            end

            // Decisions use registered PL, so a slot freed now is only
            // reusable on the next edge.
            for (int i = 0; i < 4; i++) begin
                if (w_launch && (w_slot == 2'(i))) begin
                    r_pl[i] <= 1'b1;
                    r_px[i] <= w_launch_x;
                    r_py[i] <= w_launch_y;
                end else if (r_pl[i]) begin
                    if (w_hit[i]) begin
                        r_pl[i] <= 1'b0;
                    end else if (r_py[i] >= c_SPEED) begin
                        r_py[i] <= r_py[i] - c_SPEED;
                    end else begin
                        r_pl[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign PL1         = r_pl[0];
    assign PL2         = r_pl[1];
    assign PL3         = r_pl[2];
    assign PL4         = r_pl[3];
    assign PX1         = r_px[0];
    assign PX2         = r_px[1];
    assign PX3         = r_px[2];
    assign PX4         = r_px[3];
    assign PY1         = r_py[0];
    assign PY2         = r_py[1];
    assign PY3         = r_py[2];
    assign PY4         = r_py[3];
    assign shots_fired = r_shots;

endmodule
`default_nettype wire

// File: tb/tb_player_lasers.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_player_lasers
// Description : Scoreboard bench for player_lasers with directed vectors.
// Revision    : 1.0 - initial release
//============================================================================
module tb_player_lasers;

    localparam int c_F_PL = 0;
    localparam int c_F_PX = 1;
    localparam int c_F_PY = 2;
    localparam int c_F_SH = 3;

    logic       frame_clk;
    logic       Reset;
    logic       fire;
    logic [9:0] shipX, shipY, ship_width, laser_width, laser_height;
    logic       hit1, hit2, hit3, hit4;
    logic [9:0] PX1, PX2, PX3, PX4, PY1, PY2, PY3, PY4;
    logic       PL1, PL2, PL3, PL4;
    logic [7:0] shots_fired;

    logic [9:0] w_px [4];
    logic [9:0] w_py [4];
    logic       w_pl [4];

    assign w_px[0] = PX1; assign w_px[1] = PX2; assign w_px[2] = PX3; assign w_px[3] = PX4;
    assign w_py[0] = PY1; assign w_py[1] = PY2; assign w_py[2] = PY3; assign w_py[3] = PY4;
    assign w_pl[0] = PL1; assign w_pl[1] = PL2; assign w_pl[2] = PL3; assign w_pl[3] = PL4;

    player_lasers #(.LASER_SPEED(8), .COOLDOWN(8)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire         (fire),
        .shipX        (shipX),
        .shipY        (shipY),
        .ship_width   (ship_width),
        .laser_width  (laser_width),
        .laser_height (laser_height),
        .hit1         (hit1),
        .hit2         (hit2),
        .hit3         (hit3),
        .hit4         (hit4),
        .PX1          (PX1),
        .PX2          (PX2),
        .PX3          (PX3),
        .PX4          (PX4),
        .PY1          (PY1),
        .PY2          (PY2),
        .PY3          (PY3),
        .PY4          (PY4),
        .PL1          (PL1),
        .PL2          (PL2),
        .PL3          (PL3),
        .PL4          (PL4),
        .shots_fired  (shots_fired)
    );

    typedef struct {
        int cyc;
        int fld;
        int slot;
        int val;
    } exp_t;

    exp_t q [$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) cyc <= cyc + 1;

    function automatic int actual(int fld, int slot);
        case (fld)
            c_F_PL:  return int'(w_pl[slot]);
            c_F_PX:  return int'(w_px[slot]);
            c_F_PY:  return int'(w_py[slot]);
            default: return int'(shots_fired);
        endcase
    endfunction

    function automatic string fname(int fld, int slot);
        case (fld)
            c_F_PL:  return $sformatf("PL%0d", slot + 1);
            c_F_PX:  return $sformatf("PX%0d", slot + 1);
            c_F_PY:  return $sformatf("PY%0d", slot + 1);
            default: return "shots_fired";
        endcase
    endfunction

    // Monitor: compare every expectation due at the state visible this cycle.
    always @(negedge frame_clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   a;
            e = q.pop_front();
            a = actual(e.fld, e.slot);
            n_checks++;
            if (a != e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                         fname(e.fld, e.slot), a, e.val, cyc);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    // dly = number of further rising edges before the value must be visible.
    task automatic expect_v(int dly, int fld, int slot, int val);
        exp_t e;
        e.cyc  = cyc + dly;
        e.fld  = fld;
        e.slot = slot;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        fire  = 1'b0;
        tick(2);
        Reset = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; fire = 1'b0;
        hit1 = 1'b0; hit2 = 1'b0; hit3 = 1'b0; hit4 = 1'b0;
        shipX = 10'd300; shipY = 10'd400; ship_width = 10'd32;
        laser_width = 10'd4; laser_height = 10'd16;
        tick(2);
        Reset = 1'b0;

        n_checks++;
        if (PL1 !== 1'b0) begin
            n_fail++;
            $display("FAIL PL1 after reset: got %0d, expected 0", PL1);
        end
        n_checks++;
        if (PX1 !== 10'd0) begin
            n_fail++;
            $display("FAIL PX1 after reset: got %0d, expected 0", PX1);
        end
        n_checks++;
        if (PY1 !== 10'd0) begin
            n_fail++;
            $display("FAIL PY1 after reset: got %0d, expected 0", PY1);
        end
        n_checks++;
        if (shots_fired !== 8'd0) begin
            n_fail++;
            $display("FAIL shots_fired after reset: got %0d, expected 0", shots_fired);
        end

        // Reset state
        for (int i = 0; i < 4; i++) begin
            expect_v(0, c_F_PL, i, 0);
            expect_v(0, c_F_PX, i, 0);
            expect_v(0, c_F_PY, i, 0);
        end
        expect_v(0, c_F_SH, 0, 0);
        tick(1);

        // Basic launch and first move
        fire = 1'b1;
        expect_v(1, c_F_PL, 0, 1);
        expect_v(1, c_F_PX, 0, 314);
        expect_v(1, c_F_PY, 0, 384);
        expect_v(1, c_F_SH, 0, 1);
        expect_v(2, c_F_PY, 0, 376);
        expect_v(2, c_F_PX, 0, 314);
        expect_v(2, c_F_PL, 1, 0);
        tick(1);
        fire = 1'b0;
        tick(2);

        // Off-screen exit coincident with a launch goes to slot 2
        shipY = 10'd85;
        do_reset();
        fire = 1'b1;
        expect_v(1, c_F_PY, 0, 69);
        tick(1);
        fire = 1'b0;
        tick(8);
        expect_v(0, c_F_PY, 0, 5);
        expect_v(0, c_F_PL, 0, 1);
        fire = 1'b1;
        expect_v(1, c_F_PL, 0, 0);
        expect_v(1, c_F_PY, 0, 5);
        expect_v(1, c_F_PL, 1, 1);
        expect_v(1, c_F_PY, 1, 69);
        expect_v(1, c_F_PX, 1, 314);
        expect_v(1, c_F_SH, 0, 2);
        tick(1);
        fire = 1'b0;
        expect_v(1, c_F_PY, 1, 61);
        expect_v(1, c_F_PL, 0, 0);
        tick(1);

        // Cooldown: edge at +3 dropped, edge at +9 launches
        shipY = 10'd400;
        do_reset();
        fire = 1'b1;
        tick(1);
        fire = 1'b0;
        tick(2);
        fire = 1'b1;
        expect_v(1, c_F_PL, 1, 0);
        expect_v(1, c_F_SH, 0, 1);
        tick(1);
        fire = 1'b0;
        tick(5);
        fire = 1'b1;
        expect_v(1, c_F_PL, 1, 1);
        expect_v(1, c_F_PY, 1, 384);
        expect_v(1, c_F_PY, 0, 312);
        expect_v(1, c_F_SH, 0, 2);
        tick(1);
        fire = 1'b0;
        tick(1);

        // Fill all four slots, fifth edge dropped, held fire never repeats
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fire = 1'b1;
            tick(1);
            fire = 1'b0;
            tick(8);
        end
        fire = 1'b1;
        for (int i = 0; i < 4; i++) expect_v(1, c_F_PL, i, 1);
        expect_v(1, c_F_SH, 0, 4);
        expect_v(1, c_F_PY, 3, 312);
        expect_v(1, c_F_PY, 0, 96);
        tick(1);
        tick(15);
        expect_v(0, c_F_PL, 0, 0);
        expect_v(0, c_F_PY, 0, 0);
        expect_v(0, c_F_SH, 0, 4);
        fire = 1'b0;
        tick(1);

        // Hits on slots 1 and 3, hit on inactive slot 2 ignored
        do_reset();
        for (int k = 0; k < 2; k++) begin
            fire = 1'b1;
            tick(1);
            fire = 1'b0;
            tick(8);
        end
        fire = 1'b1;
        tick(1);
        fire = 1'b0;
        hit2 = 1'b1;
        tick(1);
        hit2 = 1'b0;
        expect_v(0, c_F_PL, 1, 0);
        expect_v(0, c_F_PY, 1, 312);
        hit1 = 1'b1; hit2 = 1'b1; hit3 = 1'b1;
        expect_v(1, c_F_PL, 0, 0);
        expect_v(1, c_F_PL, 1, 0);
        expect_v(1, c_F_PL, 2, 0);
        expect_v(1, c_F_PY, 0, 232);
        expect_v(1, c_F_PY, 1, 312);
        expect_v(1, c_F_PY, 2, 376);
        expect_v(1, c_F_PX, 0, 314);
        expect_v(1, c_F_PX, 2, 314);
        expect_v(1, c_F_SH, 0, 3);
        tick(1);
        hit1 = 1'b0; hit2 = 1'b0; hit3 = 1'b0;
        expect_v(1, c_F_PY, 0, 232);
        expect_v(1, c_F_PL, 0, 0);
        tick(1);

        // Fire held through reset; PX wraps; mid-flight reset
        shipX = 10'd1020;
        Reset = 1'b1;
        fire  = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(3);
        expect_v(0, c_F_PL, 0, 0);
        expect_v(0, c_F_SH, 0, 0);
        fire = 1'b0;
        tick(1);
        fire = 1'b1;
        expect_v(1, c_F_PL, 0, 1);
        expect_v(1, c_F_PX, 0, 10);
        expect_v(1, c_F_PY, 0, 384);
        expect_v(1, c_F_SH, 0, 1);
        tick(1);
        tick(2);
        Reset = 1'b1;
        expect_v(1, c_F_PL, 0, 0);
        expect_v(1, c_F_PX, 0, 0);
        expect_v(1, c_F_PY, 0, 0);
        expect_v(1, c_F_SH, 0, 0);
        tick(1);
        Reset = 1'b0;
        fire  = 1'b0;
        tick(1);

        // shipY below laser height clamps PY to 0, then exits next edge
        shipX = 10'd300;
        shipY = 10'd10;
        do_reset();
        fire = 1'b1;
        expect_v(1, c_F_PL, 0, 1);
        expect_v(1, c_F_PY, 0, 0);
        expect_v(1, c_F_PX, 0, 314);
        expect_v(2, c_F_PL, 0, 0);
        expect_v(2, c_F_PY, 0, 0);
        tick(1);
        fire = 1'b0;
        tick(2);

        tick(2);

        n_checks++;
        if (PL1 !== 1'b0) begin
            n_fail++;
            $display("FAIL PL1 after exit: got %0d, expected 0", PL1);
        end
        n_checks++;
        if (PY1 !== 10'd0) begin
            n_fail++;
            $display("FAIL PY1 after exit: got %0d, expected 0", PY1);
        end
        n_checks++;
        if (PX1 !== 10'd314) begin
            n_fail++;
            $display("FAIL PX1 after exit: got %0d, expected 314", PX1);
        end
        n_checks++;
        if (shots_fired !== 8'd1) begin
            n_fail++;
            $display("FAIL shots_fired after exit: got %0d, expected 1", shots_fired);
        end

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: got unchecked, expected %0d at cycle %0d", fname(e.fld, e.slot), e.val, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
